// File: rtl/cutoff_sched.sv
// Per-atom sequencer that streams neighbor distances through a 3-stage cutoff pipeline.
// Define CUTOFF_SCHED_SAT_EN to make the accumulator saturate instead of wrap.
module cutoff_sched #(
    parameter int unsigned QWIDTH = 32,
    parameter int unsigned ACC_W  = 40,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [QWIDTH-1:0] rc_in,
    input  logic [QWIDTH-1:0] dr_in,
    input  logic              nb_valid,
    output logic              nb_ready,
    input  logic [QWIDTH-1:0] nb_r,
    input  logic              nb_last,
    output logic              busy,
    output logic              sum_valid,
    output logic [ACC_W-1:0]  sum,
    output logic [CNT_W-1:0]  nb_count,
    output logic [CNT_W-1:0]  in_count
);

    localparam int unsigned FRAC  = 16;
    localparam int unsigned EXT_W = ((ACC_W > QWIDTH) ? ACC_W : QWIDTH) + 1;
    localparam logic [QWIDTH-1:0] QONE = QWIDTH'(32'h0001_0000);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [QWIDTH-1:0] rc_q, rc_d;
    logic [QWIDTH-1:0] dr_q, dr_d;
    logic              s1_valid_q, s1_valid_d;
    logic [QWIDTH-1:0] s1_r_q, s1_r_d;
    logic              s2_valid_q, s2_valid_d;
    logic [QWIDTH-1:0] s2_fc_q, s2_fc_d;
    logic [ACC_W-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0]  nb_count_q, nb_count_d;
    logic [CNT_W-1:0]  in_count_q, in_count_d;

    logic accept;

    // Cutoff unit: 1 below rc-dr, (1 - x^4)^2 across the taper, 0 at/after rc or when dr = 0.
    logic signed [QWIDTH-1:0] lo;
    logic [QWIDTH-1:0]        num, divisor, x, x2, x4, t, poly, cut_fc;
    logic [QWIDTH+FRAC-1:0]   quot;
    logic [2*QWIDTH-1:0]      x2_full, x4_full, t_full;

    always_comb begin
        lo      = $signed(rc_q) - $signed(dr_q);
        num     = s1_r_q - lo;
        divisor = (dr_q == '0) ? QWIDTH'(1) : dr_q;
        quot    = {num, {FRAC{1'b0}}} / {{FRAC{1'b0}}, divisor};
        x       = QWIDTH'(quot);
        x2_full = {{QWIDTH{1'b0}}, x} * {{QWIDTH{1'b0}}, x};
        x2      = QWIDTH'(x2_full >> FRAC);
        x4_full = {{QWIDTH{1'b0}}, x2} * {{QWIDTH{1'b0}}, x2};
        x4      = QWIDTH'(x4_full >> FRAC);
        t       = QONE - x4;
        t_full  = {{QWIDTH{1'b0}}, t} * {{QWIDTH{1'b0}}, t};
        poly    = QWIDTH'(t_full >> FRAC);
        if (dr_q == '0 || $signed(s1_r_q) >= $signed(rc_q)) begin
            cut_fc = '0;
        end else if ($signed(s1_r_q) < lo) begin
            cut_fc = QONE;
        end else begin
            cut_fc = poly;
        end
    end

    logic signed [EXT_W-1:0] acc_ext, fc_ext, add_ext;
    logic [ACC_W-1:0]        acc_next;

    always_comb begin
        acc_ext = EXT_W'($signed(sum_q));
        fc_ext  = EXT_W'($signed(s2_fc_q));
        add_ext = acc_ext + fc_ext;
`ifdef CUTOFF_SCHED_SAT_EN
        if (add_ext > ((EXT_W'(1) <<< (ACC_W - 1)) - EXT_W'(1))) begin
            acc_next = {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            acc_next = ACC_W'(add_ext);
        end
`else
        acc_next = ACC_W'(add_ext);
`endif
    end

    assign accept = (state_q == StRun) && nb_valid;

    always_comb begin
        state_d    = state_q;
        rc_d       = rc_q;
        dr_d       = dr_q;
        sum_d      = sum_q;
        nb_count_d = nb_count_q;
        in_count_d = in_count_q;

        s1_valid_d = accept;
        s1_r_d     = accept ? nb_r : s1_r_q;
        s2_valid_d = s1_valid_q;
        s2_fc_d    = s1_valid_q ? cut_fc : s2_fc_q;

        if (s2_valid_q) begin
            sum_d = acc_next;
        end
        if (accept) begin
            nb_count_d = nb_count_q + CNT_W'(1);
            if ($signed(nb_r) < $signed(rc_q)) begin
                in_count_d = in_count_q + CNT_W'(1);
            end
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    rc_d       = rc_in;
                    dr_d       = dr_in;
                    sum_d      = '0;
                    nb_count_d = '0;
                    in_count_d = '0;
                    state_d    = StRun;
                end
            end
            StRun: begin
                if (accept && nb_last) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!s1_valid_q && !s2_valid_q) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rc_q       <= '0;
            dr_q       <= '0;
            s1_valid_q <= 1'b0;
            s1_r_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_fc_q    <= '0;
            sum_q      <= '0;
            nb_count_q <= '0;
            in_count_q <= '0;
        end else begin
            state_q    <= state_d;
            rc_q       <= rc_d;
            dr_q       <= dr_d;
            s1_valid_q <= s1_valid_d;
            s1_r_q     <= s1_r_d;
            s2_valid_q <= s2_valid_d;
            s2_fc_q    <= s2_fc_d;
            sum_q      <= sum_d;
            nb_count_q <= nb_count_d;
            in_count_q <= in_count_d;
        end
    end

    assign nb_ready  = (state_q == StRun);
    assign busy      = (state_q != StIdle);
    assign sum_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign nb_count  = nb_count_q;
    assign in_count  = in_count_q;

endmodule

// File: tb/tb_cutoff_sched.sv
// Scoreboard bench for cutoff_sched: a 40-bit and a 20-bit accumulator instance share stimulus.
module tb_cutoff_sched;

    localparam int unsigned QW = 32;
    localparam int unsigned CW = 16;

    typedef struct packed {
        logic [39:0] sum;
        logic [15:0] nb;
        logic [15:0] inc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, nb_valid, nb_last;
    logic [QW-1:0] rc_in, dr_in, nb_r;

    logic          nb_ready, busy, sum_valid;
    logic [39:0]   sum;
    logic [CW-1:0] nb_count, in_count;

    logic          nb_ready2, busy2, sum_valid2;
    logic [19:0]   sum2;
    logic [CW-1:0] nb_count2, in_count2;

    int total = 0;
    int bad   = 0;
    exp_t q40[$];
    exp_t q20[$];
    logic [QW-1:0] rlist [16];

    cutoff_sched #(.QWIDTH(32), .ACC_W(40), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rc_in(rc_in), .dr_in(dr_in),
        .nb_valid(nb_valid), .nb_ready(nb_ready), .nb_r(nb_r), .nb_last(nb_last),
        .busy(busy), .sum_valid(sum_valid), .sum(sum), .nb_count(nb_count),
        .in_count(in_count)
    );

    cutoff_sched #(.QWIDTH(32), .ACC_W(20), .CNT_W(16)) dut20 (
        .clk(clk), .rst_n(rst_n), .start(start), .rc_in(rc_in), .dr_in(dr_in),
        .nb_valid(nb_valid), .nb_ready(nb_ready2), .nb_r(nb_r), .nb_last(nb_last),
        .busy(busy2), .sum_valid(sum_valid2), .sum(sum2), .nb_count(nb_count2),
        .in_count(in_count2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: pop one expectation per sum_valid pulse of each instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && sum_valid) begin
            if (q40.size() == 0) begin
                chk("unexpected_sum_valid40", 64'(sum_valid), 64'd0);
            end else begin
                e = q40.pop_front();
                chk("sum40", 64'(sum), 64'(e.sum));
                chk("nb_count40", 64'(nb_count), 64'(e.nb));
                chk("in_count40", 64'(in_count), 64'(e.inc));
            end
        end
        if (rst_n && sum_valid2) begin
            if (q20.size() == 0) begin
                chk("unexpected_sum_valid20", 64'(sum_valid2), 64'd0);
            end else begin
                e = q20.pop_front();
                chk("sum20", 64'(sum2), 64'(e.sum));
                chk("nb_count20", 64'(nb_count2), 64'(e.nb));
            end
        end
    end

    task automatic run_atom(input logic [31:0] rc, input logic [31:0] dr, input int n,
                            input bit gaps, input bit poke, input logic [39:0] s40,
                            input logic [19:0] s20, input logic [15:0] nbc,
                            input logic [15:0] inc);
        int  i     = 0;
        int  guard = 0;
        logic acc;
        q40.push_back('{sum: s40, nb: nbc, inc: inc});
        q20.push_back('{sum: 40'(s20), nb: nbc, inc: inc});
        start = 1'b1;
        rc_in = rc;
        dr_in = dr;
        @(posedge clk); #1;
        start = 1'b0;
        rc_in = '0;
        dr_in = '0;
        chk("ready_after_start", 64'(nb_ready), 64'd1);
        while (i < n && guard < 200) begin
            nb_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            nb_r     = rlist[i];
            nb_last  = (i == n - 1);
            if (poke) start = 1'($urandom_range(0, 1));
            acc = nb_valid && nb_ready;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
        end
        nb_valid = 1'b0;
        nb_last  = 1'b0;
        start    = 1'b0;
        if (i < n) chk("accept_timeout", 64'(i), 64'(n));
        chk("ready_drop", 64'(nb_ready), 64'd0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("sum_valid_early", 64'(sum_valid), 64'd0);
        end
        @(posedge clk); #1;
        chk("sum_valid_latency", 64'(sum_valid), 64'd1);
        @(posedge clk); #1;
        chk("sum_valid_pulse", 64'(sum_valid), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("sum_hold", 64'(sum), 64'(s40));
        chk("nb_count_hold", 64'(nb_count), 64'(nbc));
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        nb_valid = 1'b0;
        nb_last  = 1'b0;
        rc_in    = '0;
        dr_in    = '0;
        nb_r     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(nb_ready), 64'd0);
        chk("rst_sum_valid", 64'(sum_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_nb_count", 64'(nb_count), 64'd0);
        chk("rst_in_count", 64'(in_count), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single neighbor.
        rlist[0] = 32'h0001_0000;
        run_atom(32'h0006_0000, 32'h0001_0000, 1, 0, 0, 40'h1_0000, 20'h1_0000, 16'd1, 16'd1);

        // Mixed stream, back-to-back.
        rlist[0] = 32'h0001_0000;
        rlist[1] = 32'h0005_8000;
        rlist[2] = 32'h0006_0000;
        rlist[3] = 32'h0007_0000;
        run_atom(32'h0006_0000, 32'h0001_0000, 4, 0, 0, 40'h1_E100, 20'h1_E100, 16'd4, 16'd2);

        // Same set with gaps and start pokes during RUN.
        run_atom(32'h0006_0000, 32'h0001_0000, 4, 1, 1, 40'h1_E100, 20'h1_E100, 16'd4, 16'd2);

        // Degenerate taper width.
        rlist[0] = 32'h0001_0000;
        rlist[1] = 32'h0002_0000;
        rlist[2] = 32'h0003_0000;
        run_atom(32'h0006_0000, 32'h0000_0000, 3, 0, 0, 40'h0, 20'h0, 16'd3, 16'd3);

        // Overflow of the 20-bit instance: 9 x 1.0.
        for (int k = 0; k < 9; k++) rlist[k] = 32'h0001_0000;
`ifdef CUTOFF_SCHED_SAT_EN
        run_atom(32'h0006_0000, 32'h0001_0000, 9, 0, 0, 40'h9_0000, 20'h7_FFFF, 16'd9, 16'd9);
`else
        run_atom(32'h0006_0000, 32'h0001_0000, 9, 0, 0, 40'h9_0000, 20'h9_0000, 16'd9, 16'd9);
`endif

        // Reset mid-RUN with neighbors in flight.
        start = 1'b1;
        rc_in = 32'h0006_0000;
        dr_in = 32'h0001_0000;
        @(posedge clk); #1;
        start    = 1'b0;
        nb_valid = 1'b1;
        nb_r     = 32'h0001_0000;
        nb_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_sum", 64'(sum), 64'h1_0000);
        rst_n    = 1'b0;
        nb_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ready", 64'(nb_ready), 64'd0);
        chk("mid_rst_sum", 64'(sum), 64'd0);
        chk("mid_rst_nb_count", 64'(nb_count), 64'd0);
        chk("mid_rst_in_count", 64'(in_count), 64'd0);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("leftover40", 64'(q40.size()), 64'd0);
        chk("leftover20", 64'(q20.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
